isb_lru_fifo: RTL and testbench
===============================

Name: isb_lru_fifo

Overview:
- Helper block for the ISB prefetcher.
- Holds a 4-way true-LRU replacement tracker, which supplies the training-unit victim index.
- Holds a parameterized show-ahead FIFO, which is the stream-buffer address queue (default 4 entries × 16 bits).
- The two functions share clock and reset but are otherwise independent.

Parameters:
- LOG_DEPTH, 2, log2 of FIFO depth (depth = 2**LOG_DEPTH, default 4 entries).
- DATA_W, 16, FIFO entry width (physical address width).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- lru_use_v  in  1  an entry was accessed/inserted this cycle
- lru_use_idx  in  2  index of accessed entry
- lru_idx  out  2  current least-recently-used index
- fifo_push  in  1  enqueue request
- fifo_push_data  in  DATA_W  data to enqueue
- fifo_pop  in  1  dequeue request
- fifo_flush  in  1  discard all entries
- fifo_head  out  DATA_W  oldest entry (show-ahead)
- fifo_full  out  1  count == depth
- fifo_empty  out  1  count == 0
- fifo_count  out  LOG_DEPTH+1  occupancy
- err  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (asynchronous, rst_n low):
  - LRU recency order becomes 0 (oldest), 1, 2, 3 (newest), so lru_idx = 0.
  - FIFO becomes empty: count 0, empty 1, full 0, head 0.
  - err = 0.
  - Storage contents need not be cleared; head must read 0 while empty.
- LRU:
  - Keeps a total recency order of 4 ways in state.
  - lru_idx is combinational from registered state only, so it is valid the same cycle as any state and never depends on the current inputs.
  - On a clk edge with lru_use_v=1, lru_use_idx becomes most-recent; the relative order of the other three is preserved.
  - The new lru_idx is visible after that edge (1-cycle latency).
  - Using the current MRU leaves the order unchanged.
  - Using the current LRU makes the next-oldest entry the new LRU.
  - lru_use_v=0: order is held.
- FIFO:
  - Circular buffer with read/write pointers of LOG_DEPTH bits; pointers wrap modulo depth.
  - fifo_head always presents the entry at the read pointer, with no read latency.
  - Push is accepted iff fifo_push && (!full || fifo_pop).
  - Pop is accepted iff fifo_pop && !empty.
  - Simultaneous accepted push+pop: count unchanged, both pointers advance. This applies when full.
  - Push+pop while empty: push accepted, pop ignored, count becomes 1.
  - Push while full without pop: the push is dropped and contents are unchanged.
  - Pop while empty: ignored.
  - fifo_flush has priority over push and pop in the same cycle: pointers and count are reset and the push is discarded.
  - fifo_full, fifo_empty and fifo_count are registered-state-derived and update on the edge following the operation.

Optional Feature:
- Macro: ISB_LRU_FIFO_ERR_EN.
- When defined:
  - err is set on any clk edge with a dropped push (push while full, no pop) or an ignored pop (pop while empty, no flush).
  - err stays set until rst_n is asserted.
- When undefined:
  - err is tied to constant 0 and no error logic is built.
  - All other behaviour is identical.

Test Plan:
- Reset check: assert rst_n low mid-run with the FIFO holding 3 entries and the LRU order scrambled → immediately count=0, empty=1, lru_idx=0, err=0.
- LRU ordering: use 0, 1, 2 on consecutive cycles → lru_idx goes 0→1→2→3. Then use 3 → lru_idx=0. Use 0 with the order unchanged → lru_idx=1.
- FIFO fill/drain with wrap:
  - Push 0xA000..0xA003 → full=1, count=4, head=0xA000.
  - Pop twice; push 0xB000 and 0xB001 → pointers wrap.
  - Pops return 0xA002, 0xA003, 0xB000, 0xB001 in order, then empty=1.
- Full boundary: with full=1:
  - Push 0xCCCC without pop → dropped, count stays 4, head unchanged, err=1 with ISB_LRU_FIFO_ERR_EN defined (0 without).
  - Push+pop same cycle → count stays 4 and 0xCCCC becomes the last entry.
- Empty boundary: with empty=1, push 0x1234 and pop in the same cycle → count=1, head=0x1234. A pop on an empty FIFO leaves count 0 and sets err when the macro is defined.
- Flush priority: with 2 entries, assert flush+push+pop together → count=0, empty=1. A subsequent push of 0x5555 → head=0x5555.

Source files
------------

// File: rtl/isb_lru_fifo.sv
// ISB prefetcher helper: 4-way true-LRU victim tracker plus a show-ahead address FIFO.
// Optional sticky error flag is built only when ISB_LRU_FIFO_ERR_EN is defined.
module isb_lru_fifo #(
  parameter int LOG_DEPTH = 2,
  parameter int DATA_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lru_use_v,
  input  logic [1:0]           lru_use_idx,
  output logic [1:0]           lru_idx,
  input  logic                 fifo_push,
  input  logic [DATA_W-1:0]    fifo_push_data,
  input  logic                 fifo_pop,
  input  logic                 fifo_flush,
  output logic [DATA_W-1:0]    fifo_head,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic [LOG_DEPTH:0]   fifo_count,
  output logic                 err
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  // order[0] is the oldest way, order[3] the most recently used.
  logic [1:0] order     [4];
  logic [1:0] order_nxt [4];
  logic       hit;

  always_comb begin
    order_nxt = order;
    hit       = 1'b0;
    if (lru_use_v) begin
      for (int i = 0; i < 3; i++) begin
        if (order[i] == lru_use_idx) hit = 1'b1;
        if (hit) order_nxt[i] = order[i+1];
      end
      order_nxt[3] = lru_use_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) order[i] <= 2'(i);
    end else begin
      order <= order_nxt;
    end
  end

  assign lru_idx = order[0];

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH:0]   count;
  logic                 full;
  logic                 empty;
  logic                 push_ok;
  logic                 pop_ok;

  assign full    = (count == (LOG_DEPTH+1)'(DEPTH));
  assign empty   = (count == '0);
  // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
  assign push_ok = fifo_push && (!full || fifo_pop);
  assign pop_ok  = fifo_pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (fifo_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + LOG_DEPTH'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + LOG_DEPTH'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (LOG_DEPTH+1)'(1);
        2'b01:   count <= count - (LOG_DEPTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; it is never reset and is masked at the head while empty.
  always_ff @(posedge clk) begin
    if (push_ok && !fifo_flush) mem[wr_ptr] <= fifo_push_data;
  end

  assign fifo_head  = empty ? '0 : mem[rd_ptr];
  assign fifo_full  = full;
  assign fifo_empty = empty;
  assign fifo_count = count;

`ifdef ISB_LRU_FIFO_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((fifo_push && full && !fifo_pop) || (fifo_pop && empty && !fifo_flush)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_isb_lru_fifo.sv
// Scoreboard bench for isb_lru_fifo: a queue-based reference model predicts the
// visible state after every edge and a negedge monitor compares it with the DUT.
module tb_isb_lru_fifo;

  localparam int LOG_DEPTH = 2;
  localparam int DEPTH     = 1 << LOG_DEPTH;
  localparam int DATA_W    = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              lru_use_v;
  logic [1:0]        lru_use_idx;
  logic [1:0]        lru_idx;
  logic              fifo_push;
  logic [DATA_W-1:0] fifo_push_data;
  logic              fifo_pop;
  logic              fifo_flush;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LOG_DEPTH:0] fifo_count;
  logic              err;

  isb_lru_fifo #(.LOG_DEPTH(LOG_DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .lru_use_v(lru_use_v), .lru_use_idx(lru_use_idx), .lru_idx(lru_idx),
    .fifo_push(fifo_push), .fifo_push_data(fifo_push_data), .fifo_pop(fifo_pop),
    .fifo_flush(fifo_flush), .fifo_head(fifo_head), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_count(fifo_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 step;
    logic [1:0]         lru;
    logic [DATA_W-1:0]  head;
    logic [LOG_DEPTH:0] cnt;
    logic               full;
    logic               empty;
    logic               err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;

  // Reference model: recency list (front = least recent) and a plain data queue.
  int                lru_m[$];
  logic [DATA_W-1:0] fq[$];
  bit                err_m;

  bit err_en;
  initial begin
`ifdef ISB_LRU_FIFO_ERR_EN
    err_en = 1'b1;
`else
    err_en = 1'b0;
`endif
  end

  function automatic void model_reset();
    lru_m = '{0, 1, 2, 3};
    fq.delete();
    err_m = 1'b0;
  endfunction

  function automatic void model_step(bit p, logic [DATA_W-1:0] d, bit po, bit fl, bit uv, logic [1:0] ui);
    bit is_full, is_empty;
    is_full  = (fq.size() == DEPTH);
    is_empty = (fq.size() == 0);
    if (err_en && ((p && is_full && !po) || (po && is_empty && !fl))) err_m = 1'b1;
    if (fl) begin
      fq.delete();
    end else begin
      if (po && !is_empty) void'(fq.pop_front());
      if (p && (!is_full || po)) fq.push_back(d);
    end
    if (uv) begin
      for (int i = 0; i < lru_m.size(); i++)
        if (lru_m[i] == int'(ui)) begin lru_m.delete(i); break; end
      lru_m.push_back(int'(ui));
    end
  endfunction

  function automatic void push_expected();
    exp_t e;
    e.step  = step_no;
    e.lru   = 2'(lru_m[0]);
    e.head  = (fq.size() > 0) ? fq[0] : '0;
    e.cnt   = (LOG_DEPTH+1)'(fq.size());
    e.full  = (fq.size() == DEPTH);
    e.empty = (fq.size() == 0);
    e.err   = err_m;
    exp_q.push_back(e);
  endfunction

  // Monitor: the DUT presents its state every cycle; compare half a cycle after the edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total += 6;
      if (lru_idx !== e.lru) begin bad++; $display("FAIL lru_idx step %0d: got %0d want %0d", e.step, lru_idx, e.lru); end
      if (fifo_head !== e.head) begin bad++; $display("FAIL head step %0d: got %h want %h", e.step, fifo_head, e.head); end
      if (fifo_count !== e.cnt) begin bad++; $display("FAIL count step %0d: got %0d want %0d", e.step, fifo_count, e.cnt); end
      if (fifo_full !== e.full) begin bad++; $display("FAIL full step %0d: got %b want %b", e.step, fifo_full, e.full); end
      if (fifo_empty !== e.empty) begin bad++; $display("FAIL empty step %0d: got %b want %b", e.step, fifo_empty, e.empty); end
      if (err !== e.err) begin bad++; $display("FAIL err step %0d: got %b want %b", e.step, err, e.err); end
    end
  end

  task automatic step(bit p, logic [DATA_W-1:0] d, bit po, bit fl, bit uv, logic [1:0] ui);
    fifo_push      = p;
    fifo_push_data = d;
    fifo_pop       = po;
    fifo_flush     = fl;
    lru_use_v      = uv;
    lru_use_idx    = ui;
    @(posedge clk);
    #1;
    step_no++;
    model_step(p, d, po, fl, uv, ui);
    push_expected();
  endtask

  task automatic push1(logic [DATA_W-1:0] d); step(1, d, 0, 0, 0, 2'd0); endtask
  task automatic pop1();                      step(0, '0, 1, 0, 0, 2'd0); endtask
  task automatic use1(logic [1:0] i);         step(0, '0, 0, 0, 1, i);    endtask

  // Assert reset between edges so the reset state is checked while rst_n is still low.
  task automatic do_reset();
    @(negedge clk);
    #1;
    fifo_push = 0; fifo_pop = 0; fifo_flush = 0; lru_use_v = 0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    step_no++;
    push_expected();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    fifo_push = 0; fifo_push_data = '0; fifo_pop = 0; fifo_flush = 0;
    lru_use_v = 0; lru_use_idx = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    step_no++;
    push_expected();
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // LRU ordering
    use1(2'd0); use1(2'd1); use1(2'd2); use1(2'd3); use1(2'd0);
    step(0, '0, 0, 0, 0, 2'd0);

    // Fill, partial drain, wrap, drain
    for (int i = 0; i < 4; i++) push1(16'hA000 + 16'(i));
    pop1(); pop1();
    push1(16'hB000); push1(16'hB001);
    repeat (4) pop1();

    // Full boundary
    for (int i = 0; i < 4; i++) push1(16'hD000 + 16'(i));
    push1(16'hCCCC);
    step(1, 16'hCCCC, 1, 0, 0, 2'd0);
    repeat (4) pop1();

    // Empty boundary
    step(1, 16'h1234, 1, 0, 0, 2'd0);
    pop1();
    pop1();

    // Flush priority
    push1(16'h0101); push1(16'h0202);
    step(1, 16'h0303, 1, 1, 0, 2'd0);
    push1(16'h5555);
    pop1();

    // Mid-run reset with 3 entries and scrambled LRU
    push1(16'h7001); push1(16'h7002); push1(16'h7003);
    use1(2'd2); use1(2'd0); use1(2'd3);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit p, po, fl, uv;
      p  = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 99) < 4);
      uv = ($urandom_range(0, 99) < 60);
      if (fl && p) po = 1'b1;
      step(p, 16'($urandom), po, fl, uv, 2'($urandom_range(0, 3)));
      if (n == 200) do_reset();
    end

    step(0, '0, 0, 0, 0, 2'd0);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
